mmult_result_printer: RTL

//  Consumes the packed 3x3 result matrix (9 x 18-bit, element 0 at MSB end) from the

---
 rtl/mmult_result_printer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mmult_result_printer.sv
// Streams a captured 3x3 matrix of 18-bit results as ASCII hex text, one byte per
// accepted valid/ready transfer: three rows of "XXXXX<sep>XXXXX<sep>XXXXX" plus end-of-line.
module mmult_result_printer #(
    parameter bit         HEX_UPPER = 1'b1,
    parameter logic [7:0] SEP_CHAR  = 8'h20,
    parameter bit         EOL_CRLF  = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mat_valid,
    input  logic [161:0] C_mat,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIGIT = 3'd1,
        ST_SEP   = 3'd2,
        ST_CR    = 3'd3,
        ST_LF    = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     elem_q, elem_d;
    logic [1:0]     col_q, col_d;
    logic [2:0]     digit_q, digit_d;
    logic [161:0]   mat_q, mat_d;
    logic           mv_prev_q;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           rise_s;
    logic           accept_s;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] r;
        if (nib < 4'd10) begin
            r = 8'h30 + {4'h0, nib};
        end else if (HEX_UPPER) begin
            r = 8'h41 + {4'h0, nib} - 8'd10;
        end else begin
            r = 8'h61 + {4'h0, nib} - 8'd10;
        end
        return r;
    endfunction

    // Element 0 sits at the MSB end of the packed vector.
    function automatic logic [17:0] elem_of(input logic [161:0] m, input logic [3:0] idx);
        logic [17:0] r;
        r = 18'h0;
        for (int i = 0; i < 9; i++) begin
            r = (idx == 4'(i)) ? m[161-18*i -: 18] : r;
        end
        return r;
    endfunction

    function automatic logic [3:0] nibble_of(input logic [17:0] e, input logic [2:0] d);
        logic [19:0] x;
        logic [3:0]  r;
        x = {2'b00, e};
        case (d)
            3'd0:    r = x[19:16];
            3'd1:    r = x[15:12];
            3'd2:    r = x[11:8];
            3'd3:    r = x[7:4];
            3'd4:    r = x[3:0];
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] byte_for(input state_t st, input logic [3:0] ei,
                                            input logic [2:0] di, input logic [161:0] m);
        logic [7:0] r;
        case (st)
            ST_DIGIT: r = hex_char(nibble_of(elem_of(m, ei), di));
            ST_SEP:   r = SEP_CHAR;
            ST_CR:    r = 8'h0D;
            ST_LF:    r = 8'h0A;
            default:  r = 8'h00;
        endcase
        return r;
    endfunction

    assign rise_s   = mat_valid && !mv_prev_q;
    assign accept_s = tx_valid_q && tx_ready;

    // Next-state and counter advance; everything moves only on an accepted byte.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        col_d   = col_q;
        digit_d = digit_q;
        mat_d   = mat_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_DIGIT;
                    elem_d  = 4'd0;
                    col_d   = 2'd0;
                    digit_d = 3'd0;
                    mat_d   = C_mat;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIGIT: begin
                if (accept_s) begin
                    if (digit_q == 3'd4) begin
                        digit_d = 3'd0;
                        if (col_q == 2'd2) begin
                            state_d = EOL_CRLF ? ST_CR : ST_LF;
                        end else begin
                            state_d = ST_SEP;
                        end
                    end else begin
                        digit_d = digit_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DIGIT;
                end
            end
            ST_SEP: begin
                if (accept_s) begin
                    state_d = ST_DIGIT;
                    elem_d  = elem_q + 4'd1;
                    col_d   = col_q + 2'd1;
                end else begin
                    state_d = ST_SEP;
                end
            end
            ST_CR: begin
                if (accept_s) begin
                    state_d = ST_LF;
                end else begin
                    state_d = ST_CR;
                end
            end
            ST_LF: begin
                if (accept_s) begin
                    if (elem_q == 4'd8) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_DIGIT;
                        elem_d  = elem_q + 4'd1;
                        col_d   = 2'd0;
                    end
                end else begin
                    state_d = ST_LF;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so they are registered yet show the new byte
    // on the cycle right after capture or acceptance.
    always_comb begin
        tx_data_d  = byte_for(state_d, elem_d, digit_d, mat_d);
        tx_valid_d = (state_d == ST_DIGIT) || (state_d == ST_SEP) ||
                     (state_d == ST_CR) || (state_d == ST_LF);
        busy_d     = tx_valid_d;
        done_d     = (state_d == ST_FIN);
    end

    // State, counters, captured matrix, edge detector and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            elem_q     <= 4'd0;
            col_q      <= 2'd0;
            digit_q    <= 3'd0;
            mat_q      <= 162'd0;
            mv_prev_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_q     <= elem_d;
            col_q      <= col_d;
            digit_q    <= digit_d;
            mat_q      <= mat_d;
            mv_prev_q  <= mat_valid;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
